vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//  Upstream timing stage for the VGA pattern/pixel blocks.
//  Divides the system clock into a pixel-enable strobe and runs the horizontal and vertical counters.
//  Generates the HSYNC/VSYNC pulses, the display-enable flag and the line/frame start pulses.
//  Downstream RGB generators register their colour data on PCK_EN and use HCNT/VCNT/DISP_EN for addressing.
// PARAMETERS
//  CLK_DIV  4    CLK cycles per pixel (2..16); 100 MHz -> 25 MHz pixel rate
//  HPERIOD  800  pixels per line
//  HFRONT   16   horizontal front porch, pixels
//  HWIDTH   96   HSYNC pulse width, pixels
//  HBACK    48   horizontal back porch, pixels
//  VPERIOD  525  lines per frame
//  VFRONT   10   vertical front porch, lines
//  VWIDTH   2    VSYNC pulse width, lines
//  VBACK    33   vertical back porch, lines
// PORTS
//  CLK          in   1   system clock; all state changes on posedge
//  RST          in   1   asynchronous reset, active-low
//  ENABLE       in   1   run timing; low = hold idle
//  PCK_EN       out  1   one-CLK strobe, once per CLK_DIV cycles
//  HCNT         out  10  pixel counter, 0..HPERIOD-1
//  VCNT         out  10  line counter, 0..VPERIOD-1
//  VGA_HS       out  1   horizontal sync, active-low
//  VGA_VS       out  1   vertical sync, active-low
//  DISP_EN      out  1   high in the visible area
//  LINE_START   out  1   one-CLK pulse on the PCK_EN where HCNT becomes 0
//  FRAME_START  out  1   one-CLK pulse on the PCK_EN where HCNT and VCNT both become 0
// BEHAVIOUR
//  Reset (RST=0, asynchronous, takes effect without a clock edge):
//   - Counters: divider=0, HCNT=0, VCNT=0.
//   - Outputs: PCK_EN=0, LINE_START=0, FRAME_START=0, DISP_EN=0, VGA_HS=1, VGA_VS=1.
//   - Release is sampled synchronously; the first PCK_EN follows CLK_DIV CLK edges after release.
//  Divider:
//   - Counts 0..CLK_DIV-1 while ENABLE=1.
//   - PCK_EN is registered and high for the single CLK cycle after the divider wraps.
//  Counters (advance only on cycles with PCK_EN=1):
//   - HCNT increments and wraps HPERIOD-1 -> 0.
//   - On that wrap VCNT increments and wraps VPERIOD-1 -> 0.
//   - Simultaneous H and V wrap: both return to 0 on the same edge.
//  Line origin: HCNT=0 is the first front-porch pixel. Order is front porch, sync, back porch, active.
//   - HBLANK = HFRONT+HWIDTH+HBACK (160); VBLANK = VFRONT+VWIDTH+VBACK (45).
//  Decodes, all registered and decoded from the next-count values so they align with the HCNT/VCNT they describe:
//   - VGA_HS=0 iff HFRONT <= HCNT < HFRONT+HWIDTH.
//   - VGA_VS=0 iff VFRONT <= VCNT < VFRONT+VWIDTH. VS changes only at HCNT=0.
//   - DISP_EN=1 iff HCNT >= HBLANK && VCNT >= VBLANK.
//  Start pulses: LINE_START and FRAME_START coincide with PCK_EN and last exactly one CLK.
//  ENABLE low (sampled each CLK):
//   - Divider, HCNT and VCNT are cleared to 0 on the next edge.
//   - PCK_EN=0, VGA_HS=1, VGA_VS=1, DISP_EN=0, start pulses 0.
//   - On re-enable, timing restarts exactly as after reset release, with no partial line emitted.
//  Width rules: counters are 10 bits. Parameter sums must satisfy HPERIOD,VPERIOD <= 1023 and HBLANK < HPERIOD.
// TESTING
//  T1 reset: RST=0 mid-line at HCNT=300 -> all outputs take reset values with no CLK edge; after release, PCK_EN first high on CLK edge 4 and HCNT=1.
//  T2 divider: ENABLE=1, run 40 CLK -> PCK_EN high exactly 10 cycles, spaced 4 CLK apart, each 1 CLK wide.
//  T3 hsync: one line -> VGA_HS low for HCNT 16..111 only (384 CLK); HCNT wraps 799 -> 0 and VCNT 0 -> 1 on the same edge.
//  T4 frame: full frame of 525x800 pixels -> VGA_VS low for VCNT 10..11; FRAME_START once, at VCNT=0 and HCNT=0; LINE_START 525 times.
//  T5 active area: count PCK_EN cycles with DISP_EN=1 over one frame -> 307200; DISP_EN first high at HCNT=160, VCNT=45.
//  T6 enable gating: ENABLE=0 at VCNT=200 -> next edge HCNT=VCNT=0, HS=VS=1, no PCK_EN; ENABLE=1 -> restarts as in T1.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA timing stage: pixel-enable divider, H/V counters, registered sync,
// display-enable and line/frame start decodes aligned to HCNT/VCNT.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned HPERIOD = 800,
  parameter int unsigned HFRONT  = 16,
  parameter int unsigned HWIDTH  = 96,
  parameter int unsigned HBACK   = 48,
  parameter int unsigned VPERIOD = 525,
  parameter int unsigned VFRONT  = 10,
  parameter int unsigned VWIDTH  = 2,
  parameter int unsigned VBACK   = 33
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ENABLE,
  output logic       PCK_EN,
  output logic [9:0] HCNT,
  output logic [9:0] VCNT,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       DISP_EN,
  output logic       LINE_START,
  output logic       FRAME_START
);

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(HPERIOD - 1);
  localparam logic [9:0] V_LAST   = 10'(VPERIOD - 1);
  localparam logic [9:0] HS_BEG   = 10'(HFRONT);
  localparam logic [9:0] HS_END   = 10'(HFRONT + HWIDTH);
  localparam logic [9:0] VS_BEG   = 10'(VFRONT);
  localparam logic [9:0] VS_END   = 10'(VFRONT + VWIDTH);
  localparam logic [9:0] HBLANK   = 10'(HFRONT + HWIDTH + HBACK);
  localparam logic [9:0] VBLANK   = 10'(VFRONT + VWIDTH + VBACK);

  logic [3:0] div_q, div_d;
  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;
  logic       pck_q, pck_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       de_q, de_d;
  logic       ls_q, ls_d;
  logic       fs_q, fs_d;
  logic       tick;

  always_comb begin
    tick   = ENABLE && (div_q == DIV_LAST);
    div_d  = '0;
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;

    if (!ENABLE) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end else begin
      div_d = tick ? '0 : div_q + 4'd1;
      if (tick) begin
        if (hcnt_q == H_LAST) begin
          hcnt_d = '0;
          vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
        end else begin
          hcnt_d = hcnt_q + 10'd1;
        end
      end
    end

    // Decodes look at the next counts so each flag lands with the count it describes.
    pck_d = tick;
    hs_d  = !(ENABLE && (hcnt_d >= HS_BEG) && (hcnt_d < HS_END));
    vs_d  = !(ENABLE && (vcnt_d >= VS_BEG) && (vcnt_d < VS_END));
    de_d  = ENABLE && (hcnt_d >= HBLANK) && (vcnt_d >= VBLANK);
    ls_d  = tick && (hcnt_d == '0);
    fs_d  = tick && (hcnt_d == '0) && (vcnt_d == '0);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      div_q  <= '0;
      hcnt_q <= '0;
      vcnt_q <= '0;
      pck_q  <= 1'b0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      de_q   <= 1'b0;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      pck_q  <= pck_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      de_q   <= de_d;
      ls_q   <= ls_d;
      fs_q   <= fs_d;
    end
  end

  assign PCK_EN      = pck_q;
  assign HCNT        = hcnt_q;
  assign VCNT        = vcnt_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign DISP_EN     = de_q;
  assign LINE_START  = ls_q;
  assign FRAME_START = fs_q;

endmodule
